// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM shared by the CPU (port 0)
// and the VGA fetch engine (port 1).
module mem_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 8,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          clr,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          urgent1,
    output logic          gnt1,
    output logic          rvalid1,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [7:0]    starve_cnt
);

    localparam logic [7:0] STARVE_L = 8'(STARVE);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P0   = 2'd1,
        SEL_P1   = 2'd2
    } sel_e;

    sel_e       sel;
    logic       last_q, last_d;
    logic [7:0] wait0_q, wait0_d;
    logic       rtag_vld_q, rtag_vld_d;
    logic       rtag_port_q, rtag_port_d;
    logic       starved;

    assign starved = (wait0_q >= STARVE_L);

    // Winner selection; clr masks all grants so the memory is untouched in reset.
    always_comb begin
        sel = SEL_NONE;
        if (!clr) begin
            if (req0 && !req1) begin
                sel = SEL_P0;
            end else if (req1 && !req0) begin
                sel = SEL_P1;
            end else if (req0 && req1) begin
                if (starved) begin
                    sel = SEL_P0;
                end else if (urgent1) begin
                    sel = SEL_P1;
                end else if (last_q) begin
                    sel = SEL_P0;
                end else begin
                    sel = SEL_P1;
                end
            end
        end
    end

    assign gnt0 = (sel == SEL_P0);
    assign gnt1 = (sel == SEL_P1);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        if (sel == SEL_P0) begin
            mem_en = 1'b1;
            mem_we = we0;
        end else if (sel == SEL_P1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_comb begin
        last_d      = last_q;
        wait0_d     = 8'd0;
        rtag_vld_d  = 1'b0;
        rtag_port_d = 1'b0;
        if (sel != SEL_NONE) begin
            last_d      = (sel == SEL_P1);
            rtag_vld_d  = !mem_we;
            rtag_port_d = (sel == SEL_P1);
        end
        if (req0 && !gnt0) begin
            wait0_d = (wait0_q == 8'hFF) ? 8'hFF : wait0_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_q      <= 1'b1;
            wait0_q     <= 8'd0;
            rtag_vld_q  <= 1'b0;
            rtag_port_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            wait0_q     <= wait0_d;
            rtag_vld_q  <= rtag_vld_d;
            rtag_port_q <= rtag_port_d;
        end
    end

    // Gating with clr hides a read that was granted just before reset asserted.
    assign rvalid0    = rtag_vld_q && !rtag_port_q && !clr;
    assign rvalid1    = rtag_vld_q &&  rtag_port_q && !clr;
    assign rdata      = mem_rdata;
    assign starve_cnt = wait0_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter with a behavioural arbitration
// model and a shadow memory predicting read data.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int STARVE = 4;

    logic          clk;
    logic          clr;
    logic          req0, we0, req1, we1, urgent1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    starve_cnt;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .urgent1(urgent1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .starve_cnt(starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The RAM the arbiter fronts: one access per cycle, registered read.
    bit [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Behavioural reference: who last won, how long port 0 has waited,
    // and which read (if any) returns data this cycle.
    bit          model_ok = 0;
    int          m_last, m_wait, m_pp;
    bit          m_pv;
    logic [DW-1:0] m_pdata;
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];

    function automatic int winner();
        if (clr) return -1;
        if (!req0 && !req1) return -1;
        if (req0 && !req1) return 0;
        if (req1 && !req0) return 1;
        if (m_wait >= STARVE) return 0;
        if (urgent1) return 1;
        return 1 - m_last;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_upd
        int w;
        w = winner();
        if (clr) begin
            model_ok = 1;
            m_last = 1;
            m_wait = 0;
            m_pv = 0;
            m_pp = 0;
        end else if (model_ok) begin
            if (w >= 0) m_last = w;
            if (req0 && w != 0) m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
            else                m_wait = 0;
            m_pv = 0;
            if (w == 0) begin
                if (we0) ref_mem[addr0] = wdata0;
                else begin m_pv = 1; m_pp = 0; m_pdata = ref_mem[addr0]; end
            end else if (w == 1) begin
                if (we1) ref_mem[addr1] = wdata1;
                else begin m_pv = 1; m_pp = 1; m_pdata = ref_mem[addr1]; end
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        if (model_ok) begin
            w = winner();
            chk("gnt0", 32'(gnt0), 32'(w == 0));
            chk("gnt1", 32'(gnt1), 32'(w == 1));
            chk("mem_en", 32'(mem_en), 32'(w >= 0));
            chk("mem_we", 32'(mem_we), 32'((w == 0) ? we0 : (w == 1) ? we1 : 1'b0));
            chk("mem_addr", 32'(mem_addr), 32'((w == 1) ? addr1 : addr0));
            chk("mem_wdata", 32'(mem_wdata), 32'((w == 1) ? wdata1 : wdata0));
            chk("rvalid0", 32'(rvalid0), 32'(m_pv && m_pp == 0 && !clr));
            chk("rvalid1", 32'(rvalid1), 32'(m_pv && m_pp == 1 && !clr));
            if (m_pv && !clr) chk("rdata", 32'(rdata), 32'(m_pdata));
            chk("starve_cnt", 32'(starve_cnt), 32'(m_wait));
        end
    end

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic step(input bit c, input bit r0, input bit w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input bit r1, input bit w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit u);
        @(posedge clk);
        #1;
        clr = c; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; urgent1 = u;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 0);
    endtask

    initial begin : stim
        bit g0, g1;
        clr = 1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; urgent1 = 0;

        // Reset held with both ports requesting.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 12'h5, 8'h0, 1, 0, 12'h6, 8'h0, 0);
            chk("rst_gnt0", 32'(gnt0), 0);
            chk("rst_gnt1", 32'(gnt1), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_rvalid0", 32'(rvalid0), 0);
            chk("rst_rvalid1", 32'(rvalid1), 0);
        end

        // Round-robin: first tie after reset goes to port 0, then alternates.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 12'h5, 8'h0, 1, 0, 12'h6, 8'h0, 0);
            chk("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            chk("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            if (i > 0) chk("rr_rvalid0", 32'(rvalid0), 32'(i % 2 == 1));
            chk("rr_starve_le1", 32'(starve_cnt <= 8'd1), 1);
        end
        idle();

        // Urgent port 1 until port 0 starves.
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 12'h7, 8'h0, 1, 0, 12'h8, 8'h0, 1);
            chk("urg_gnt0", 32'(gnt0), 32'(k == 4));
            chk("urg_gnt1", 32'(gnt1), 32'(k != 4));
            chk("urg_starve", 32'(starve_cnt), (k <= 4) ? 32'(k) : 0);
        end
        idle();

        // Write by port 0, read back by port 1.
        step(0, 1, 1, 12'h123, 8'h41, 0, 0, 12'h0, 8'h0, 0);
        chk("wr_gnt0", 32'(gnt0), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        step(0, 0, 0, 12'h0, 8'h0, 1, 0, 12'h123, 8'h0, 0);
        chk("rd_gnt1", 32'(gnt1), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        chk("wr_no_rvalid0", 32'(rvalid0), 0);
        idle();
        chk("rd_rvalid1", 32'(rvalid1), 1);
        chk("rd_rdata", 32'(rdata), 32'h41);
        chk("rd_rvalid0", 32'(rvalid0), 0);

        // Port 1 streaming alone.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 12'h0, 8'h0, 1, 0, 12'(i), 8'h0, 0);
            chk("st_gnt1", 32'(gnt1), 1);
            chk("st_rvalid1", 32'(rvalid1), 32'(i > 0));
            chk("st_starve", 32'(starve_cnt), 0);
        end
        idle();

        // Reset right after a granted port 0 read.
        step(0, 1, 0, 12'h9, 8'h0, 0, 0, 12'h0, 8'h0, 0);
        chk("mr_gnt0", 32'(gnt0), 1);
        step(1, 0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 0);
        chk("mr_rvalid0_clr", 32'(rvalid0), 0);
        idle();
        chk("mr_rvalid0_after", 32'(rvalid0), 0);

        // Random traffic; a losing requester keeps its request unchanged.
        g0 = 0; g1 = 0;
        for (int n = 0; n < 3000; n++) begin
            bit c, r0, w0, r1, w1, u;
            logic [AW-1:0] a0, a1;
            logic [DW-1:0] d0, d1;
            c = ($urandom_range(63) == 0);
            u = ($urandom_range(9) < 3);
            if (req0 && !g0) begin
                r0 = 1; w0 = we0; a0 = addr0; d0 = wdata0;
            end else begin
                r0 = ($urandom_range(9) < 6); w0 = $urandom_range(1);
                a0 = 12'($urandom_range(15)); d0 = 8'($urandom);
            end
            if (req1 && !g1) begin
                r1 = 1; w1 = we1; a1 = addr1; d1 = wdata1;
            end else begin
                r1 = ($urandom_range(9) < 6); w1 = ($urandom_range(3) == 0);
                a1 = 12'($urandom_range(15)); d1 = 8'($urandom);
            end
            step(c, r0, w0, a0, d0, r1, w1, a1, d1, u);
            g0 = gnt0;
            g1 = gnt1;
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for a single-port synchronous memory, such as the VGA character RAM, shared between the CPU's MMIO write/read path and the VGA scan-out fetch engine. Each cycle it selects at most one requester. It drives the shared memory port and returns read data to the winning requester one cycle later with a tagged valid. Selection is round-robin, with an urgent override for the real-time VGA side and a starvation guard for the CPU side.

## Interface
- AW, 12, address width
- DW, 8, data width
- STARVE, 8, number of consecutive losing cycles after which port 0 is forced to win (range 1..255)
- clk  in  1  system clock (CLK50MHZ domain); everything is rising-edge
- clr  in  1  reset, synchronous, active-high
- req0  in  1  port 0 (CPU) request; held until gnt0
- we0  in  1  port 0 write enable; sampled with req0
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  port 0 granted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (registered)
- req1, we1, addr1, wdata1  in  1/1/AW/DW  port 1 (VGA fetch), same meaning as port 0
- urgent1  in  1  port 1 deadline pressure; overrides round-robin
- gnt1  out  1  port 1 granted this cycle
- rvalid1  out  1  port 1 read data valid
- rdata  out  DW  read data, shared by both ports; qualified by rvalidN
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en && !mem_we
- starve_cnt  out  8  current port 0 wait count (debug)

## Operation
- Registered state:
  - last: the most recently granted port
  - wait0: 8-bit count of cycles port 0 has lost
  - rtag: 2-bit pending read, {valid, port}
- Winner selection, evaluated combinationally each cycle, first matching rule applies:
  1. Only one req is high: that port wins.
  2. Both high and wait0 ≥ STARVE: port 0 wins.
  3. Both high and urgent1: port 1 wins.
  4. Both high otherwise: the port that is not `last` wins.
  5. Neither high: no grant.
- On a grant, gntN=1, mem_en=1, and mem_we/addr/wdata are driven from the winner. With no grant, mem_en=0, mem_we=0, and addr/wdata hold the port 0 values (don't-care).
- last updates to the winner on every grant and holds otherwise.
- wait0 behaviour:
  - Increments when req0 && !gnt0, saturating at 255.
  - Clears to 0 when gnt0 or !req0.
  - starve_cnt = wait0.
- Read return:
  - A granted read (we=0) sets rtag={1, winner}; any other cycle sets rtag={0, x}.
  - rvalidN = rtag.valid && rtag.port==N.
  - rdata = mem_rdata passed through; it is meaningful only when some rvalid is high.
- Writes produce no rvalid.
- A requester may re-assert req in the cycle of its rvalid. Back-to-back grants to the same port are allowed when the other port is idle.
- Reset (clr=1 at a rising edge):
  - last=1, so port 0 wins the first tie.
  - wait0=0, rtag=0.
  - While clr is high, gnt0=gnt1=mem_en=mem_we=0 regardless of req.
  - A read granted in the cycle before clr asserted has its rvalid suppressed.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req in the same cycle.
- Read data latency is 1 cycle: rvalidN is high exactly one cycle after the granting edge, for exactly one cycle.
- Throughput is 1 access per cycle.
- A waiting port 0 is served within at most STARVE+1 cycles of continuous contention. Without urgent1 it is served within 2 cycles, because round-robin alternates.
- Simultaneous starvation and urgent: starvation wins. Port 1's urgent request is served the next cycle, since it is then the only requester or round-robin favours it.
- Reset mid-read: rvalid is 0 in the cycle after clr, and state is restarted from reset values.

## Test plan
- Reset: hold clr 2 cycles with req0=req1=1 -> gnt0=gnt1=mem_en=0, rvalid0=rvalid1=0. First cycle after reset with both req -> gnt0=1.
- Round-robin: req0=req1=1, both reads, urgent1=0, for 6 cycles -> grants alternate 0,1,0,1,0,1. rvalid follows one cycle later with the matching port and rdata=mem_rdata. starve_cnt never exceeds 1.
- Urgent with starvation (STARVE=4): req0=req1=1, urgent1=1 held -> gnt1 for 4 cycles with starve_cnt 1,2,3,4. The 5th cycle gives gnt0 and starve_cnt returns to 0, then gnt1 resumes.
- Write/read ordering:
  - Port 0 writes 0x41 to address 0x123 while port 1 is idle, then port 1 reads 0x123 the next cycle -> mem_we=1 then mem_we=0.
  - rvalid1=1 one cycle after the read with rdata=0x41, and rvalid0 stays 0 throughout.
- Single requester streaming: req1 only, 8 consecutive reads -> gnt1 every cycle and rvalid1 every cycle from the second cycle onward. wait0 stays 0.
- Reset mid-read: grant a port 0 read, assert clr on the next edge -> rvalid0=0 in the following cycle.
